// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: round count, FSM encoding, GF(2^8) helpers
// and the linear inverse-round transforms over a 128-bit column-major state.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    // Byte k of the block (bits [127-8k -: 8]) lives at index 15-k.
    typedef logic [15:0][7:0] block_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Row r of column c takes the byte from column (c - r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        block_t b_in;
        block_t b_out;
        b_in  = s;
        b_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b_out[15 - (4 * c + r)] = b_in[15 - (4 * ((c - r + 4) % 4) + r)];
            end
        end
        return b_out;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        block_t b_in;
        block_t b_out;
        logic [7:0] a0, a1, a2, a3;
        b_in  = s;
        b_out = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = b_in[15 - 4 * c];
            a1 = b_in[14 - 4 * c];
            a2 = b_in[13 - 4 * c];
            a3 = b_in[12 - 4 * c];
            b_out[15 - 4 * c] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
            b_out[14 - 4 * c] = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
            b_out[13 - 4 * c] = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
            b_out[12 - 4 * c] = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
        end
        return b_out;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: combinational 8-bit lookup, one row of the table per high nibble.
module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [127:0] ROWS [16] = '{
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [127:0] row;

    assign row = ROWS[a[7:4]];
    // Column c sits at bit offset 8*(15-c); 15-c is the nibble complement.
    assign y = row[{~a[3:0], 3'b000} +: 8];

endmodule

// File: rtl/inv_cipher_core.sv
// Iterative AES-128 InvCipher: one inverse round per clock, round keys fetched by index
// from an external combinational store, plaintext held until the downstream accepts it.
module inv_cipher_core #(
    parameter int NR = aes_pkg::NR
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic [127:0] iData,
    input  logic         iValid,
    output logic         oReady,
    output logic [3:0]   oRkAddr,
    input  logic [127:0] iRoundKey,
    output logic [127:0] oData,
    output logic         oValid,
    input  logic         iReady
);
    import aes_pkg::*;

    state_t       state_reg, state_next;
    logic [3:0]   round_reg, round_next;
    logic [127:0] data_reg, data_next;
    logic [127:0] out_reg, out_next;
    logic         valid_reg, valid_next;
    logic [3:0]   rk_addr;

    logic [127:0] shifted;
    logic [127:0] sub_bytes;
    logic [127:0] add_key;

    // ROUND and FINAL share the same InvShiftRows/InvSubBytes/AddRoundKey front end.
    assign shifted = inv_shift_rows(data_reg);

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
            inv_sbox u_inv_sbox (
                .a (shifted[127 - 8 * gi -: 8]),
                .y (sub_bytes[127 - 8 * gi -: 8])
            );
        end
    endgenerate

    assign add_key = sub_bytes ^ iRoundKey;

    always_comb begin
        state_next = state_reg;
        round_next = round_reg;
        data_next  = data_reg;
        out_next   = out_reg;
        valid_next = valid_reg;
        rk_addr    = 4'd0;
        case (state_reg)
            ST_IDLE: begin
                rk_addr = 4'(NR);
                if (iValid) begin
                    data_next  = iData ^ iRoundKey;
                    round_next = 4'(NR - 1);
                    state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rk_addr    = round_reg;
                data_next  = inv_mix_columns(add_key);
                round_next = round_reg - 4'd1;
                if (round_reg == 4'd1) begin
                    state_next = ST_FINAL;
                end
            end
            ST_FINAL: begin
                out_next   = add_key;
                valid_next = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (iReady) begin
                    valid_next = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg <= ST_IDLE;
            round_reg <= 4'd0;
            data_reg  <= '0;
            out_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            round_reg <= round_next;
            data_reg  <= data_next;
            out_reg   <= out_next;
            valid_reg <= valid_next;
        end
    end

    assign oReady  = (state_reg == ST_IDLE);
    assign oRkAddr = rk_addr;
    assign oData   = out_reg;
    assign oValid  = valid_reg;

endmodule

// File: tb/tb_inv_cipher_core.sv
// Directed bench for inv_cipher_core: FIPS-197 vectors, backpressure, mid-block reset,
// ignored input, with round keys expanded by the bench and a queue of expected plaintexts.
module tb_inv_cipher_core;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic [127:0] iData = '0;
    logic         iValid = 1'b0;
    logic         oReady;
    logic [3:0]   oRkAddr;
    logic [127:0] iRoundKey;
    logic [127:0] oData;
    logic         oValid;
    logic         iReady = 1'b0;

    logic [7:0]   sb_a = '0;
    logic [7:0]   sb_y;

    int           vectors = 0;
    int           miscompares = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   fsbox [256];
    logic [127:0] rk_mem [11];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    always #5 iClk = ~iClk;

    assign iRoundKey = (oRkAddr <= 4'd10) ? rk_mem[oRkAddr] : '0;

    inv_cipher_core #(.NR(10)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iData     (iData),
        .iValid    (iValid),
        .oReady    (oReady),
        .oRkAddr   (oRkAddr),
        .iRoundKey (iRoundKey),
        .oData     (oData),
        .oValid    (oValid),
        .iReady    (iReady)
    );

    inv_sbox u_sbox (
        .a (sb_a),
        .y (sb_y)
    );

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] m;
        logic [7:0] n;
        p = '0;
        m = x;
        n = y;
        for (int i = 0; i < 8; i++) begin
            if (n[0]) p = p ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
            n = n >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    // Forward S-box from first principles: GF inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            fsbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {fsbox[t[31:24]], fsbox[t[23:16]], fsbox[t[15:8]], fsbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_mem[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [127:0] ct, input logic [127:0] pt);
        int n;
        n = 0;
        while (!oReady && n < 40) begin
            @(negedge iClk);
            n++;
        end
        chk("accept_ready", 128'(oReady), 128'(1));
        chk("idle_rk_addr", 128'(oRkAddr), 128'(10));
        iData  = ct;
        iValid = 1'b1;
        exp_q.push_back(pt);
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0;
        iData  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic collect(input int ready_delay, input bit garbage);
        int           cnt;
        logic [3:0]   addr_log [10];
        bit           ready_bad;
        bit           hold_bad;
        logic [39:0]  seq_obs;
        logic [39:0]  seq_exp;
        logic [127:0] held;
        logic [127:0] expv;
        cnt = 0;
        ready_bad = 1'b0;
        hold_bad = 1'b0;
        seq_obs = '0;
        seq_exp = '0;
        for (int k = 0; k < 10; k++) addr_log[k] = 4'hf;
        while (!oValid && cnt < 40) begin
            if (cnt < 10) addr_log[cnt] = oRkAddr;
            if (oReady) ready_bad = 1'b1;
            if (garbage && cnt == 3) begin
                iValid = 1'b1;
                iData  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (garbage && cnt == 5) iValid = 1'b0;
            cnt++;
            @(negedge iClk);
        end
        iValid = 1'b0;
        chk("latency", 128'(cnt), 128'(10));
        if (cnt >= 40) return;
        chk("busy_ready_low", 128'(ready_bad), 128'(0));
        for (int k = 0; k < 10; k++) begin
            seq_obs = {seq_obs[35:0], addr_log[k]};
            seq_exp = {seq_exp[35:0], 4'(9 - k)};
        end
        chk("rk_addr_seq", 128'(seq_obs), 128'(seq_exp));
        chk("done_rk_addr", 128'(oRkAddr), 128'(0));
        held = oData;
        for (int d = 0; d < ready_delay; d++) begin
            @(negedge iClk);
            if (oData !== held || oValid !== 1'b1 || oReady !== 1'b0) hold_bad = 1'b1;
        end
        chk("backpressure_hold", 128'(hold_bad), 128'(0));
        iReady = 1'b1;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("plaintext", oData, expv);
        @(posedge iClk);
        @(negedge iClk);
        iReady = 1'b0;
        chk("valid_drop", 128'(oValid), 128'(0));
        chk("ready_back", 128'(oReady), 128'(1));
    endtask

    initial begin
        logic [7:0] sb_in  [5];
        logic [7:0] sb_out [5];
        int         bad;

        build_sbox();

        // Reset state
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        chk("rst_valid", 128'(oValid), 128'(0));
        chk("rst_data", oData, 128'(0));
        chk("rst_ready", 128'(oReady), 128'(1));
        chk("rst_rk_addr", 128'(oRkAddr), 128'(10));
        iRst = 1'b0;

        // Inverse S-box: known points, then the whole table against the derived forward box
        sb_in  = '{8'h82, 8'h63, 8'h16, 8'h00, 8'h09};
        sb_out = '{8'h11, 8'h00, 8'hff, 8'h52, 8'h40};
        for (int i = 0; i < 5; i++) begin
            sb_a = sb_in[i];
            #1;
            chk("inv_sbox_point", 128'(sb_y), 128'(sb_out[i]));
        end
        bad = 0;
        for (int x = 0; x < 256; x++) begin
            sb_a = 8'(x);
            #1;
            if (fsbox[sb_y] !== 8'(x)) bad++;
        end
        chk("inv_sbox_table", 128'(bad), 128'(0));
        @(negedge iClk);

        // FIPS-197 C.1 then Appendix B, back to back
        load_key(C1_KEY);
        send(C1_CT, C1_PT);
        collect(0, 1'b0);
        load_key(B_KEY);
        send(B_CT, B_PT);
        collect(0, 1'b0);

        // Backpressure for 5 cycles, then B immediately after
        load_key(C1_KEY);
        send(C1_CT, C1_PT);
        collect(5, 1'b0);
        load_key(B_KEY);
        send(B_CT, B_PT);
        collect(0, 1'b0);

        // Reset at ROUND cycle 4 discards the block
        load_key(C1_KEY);
        send(C1_CT, C1_PT);
        repeat (3) @(negedge iClk);
        iRst = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        chk("midrst_valid", 128'(oValid), 128'(0));
        chk("midrst_data", oData, 128'(0));
        chk("midrst_ready", 128'(oReady), 128'(1));
        iRst = 1'b0;
        exp_q.delete();
        send(C1_CT, C1_PT);
        collect(0, 1'b0);

        // iValid pulsed with garbage mid-block is ignored, no extra output follows
        load_key(B_KEY);
        send(B_CT, B_PT);
        collect(2, 1'b1);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge iClk);
            if (oValid !== 1'b0 || oReady !== 1'b1) bad++;
        end
        chk("no_extra_output", 128'(bad), 128'(0));

        // Reset and iValid together: no accept
        iRst   = 1'b1;
        iValid = 1'b1;
        iData  = C1_CT;
        @(posedge iClk);
        @(negedge iClk);
        iRst   = 1'b0;
        iValid = 1'b0;
        chk("reset_wins", 128'(oReady), 128'(1));
        @(negedge iClk);
        chk("reset_wins_idle", 128'(oReady), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
